// File: rtl/card_deal_seq.sv
// card_deal_seq: baccarat card-load sequencer.
// Steps through the deal slots P1 D1 P2 D2, waits for the third-card decision,
// then deals P3 and/or D3. Each slot gives one load strobe plus a card value.
// An optional DEAL_GAP idle period follows every slot.
// Build option: define CARD_LFSR_EN to take cards from an 8-bit LFSR instead
// of the wrap counter.
module card_deal_seq #(
   parameter int unsigned DEAL_GAP = 0,
   parameter int unsigned CARD_MAX = 13
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       start,
   input  logic       decide,
   input  logic       player_draw,
   input  logic       dealer_draw,
   output logic [3:0] new_card,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_P1    = 4'd1;
   localparam logic [3:0] S_D1    = 4'd2;
   localparam logic [3:0] S_P2    = 4'd3;
   localparam logic [3:0] S_D2    = 4'd4;
   localparam logic [3:0] S_WAIT3 = 4'd5;
   localparam logic [3:0] S_P3    = 4'd6;
   localparam logic [3:0] S_D3    = 4'd7;
   localparam logic [3:0] S_GAP   = 4'd8;
   localparam logic [3:0] S_DONE  = 4'd9;

   // GAP counts down from DEAL_GAP-1 to 0, giving DEAL_GAP cycles in GAP
   localparam logic [3:0] GAP_LOAD = (DEAL_GAP > 0) ? 4'(DEAL_GAP - 1) : 4'd0;
   localparam logic [3:0] CMAX     = 4'(CARD_MAX);

   logic [3:0] r_state;
   logic [3:0] r_ret;
   logic [3:0] r_gap_cnt;
   logic       r_ddraw;
   logic [3:0] w_nxt;
   logic [3:0] w_follow;
   logic       w_slot;
   logic       w_enter_slot;
   logic [3:0] w_card;

`ifdef CARD_LFSR_EN
   localparam logic [7:0] LFSR_SEED = 8'h5A;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;   // x^8 + x^6 + x^5 + x^4 + 1

   logic [7:0] r_lfsr;
   logic [7:0] w_lfsr_step;

   // Galois step and mapping of the LFSR value into 1..CARD_MAX
   always_comb begin
      w_lfsr_step = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
      w_card      = 4'((r_lfsr % 8'(CARD_MAX)) + 8'd1);
   end

   // Card source LFSR, free-running; reloads the seed if it ever locks at zero
   always_ff @(posedge slow_clock) begin
      if (resetb)             r_lfsr <= LFSR_SEED;
      else if (r_lfsr == '0)  r_lfsr <= LFSR_SEED;
      else                    r_lfsr <= w_lfsr_step;
   end
`else
   logic [3:0] r_src;

   // Card value is the wrap counter itself
   always_comb w_card = r_src;

   // Card source counter 1..CARD_MAX, free-running in every state
   always_ff @(posedge slow_clock) begin
      if (resetb)             r_src <= 4'd1;
      else if (r_src >= CMAX) r_src <= 4'd1;
      else                    r_src <= r_src + 4'd1;
   end
`endif

   // Next-state logic; slots share one exit path so the gap rule sits in one place
   always_comb begin
      w_nxt    = r_state;
      w_follow = r_state;
      w_slot   = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_nxt = S_P1;
         S_P1:    begin w_slot = 1'b1; w_follow = S_D1;    end
         S_D1:    begin w_slot = 1'b1; w_follow = S_P2;    end
         S_P2:    begin w_slot = 1'b1; w_follow = S_D2;    end
         S_D2:    begin w_slot = 1'b1; w_follow = S_WAIT3; end
         S_WAIT3: begin
            if (decide) begin
               if (player_draw)      w_nxt = S_P3;
               else if (dealer_draw) w_nxt = S_D3;
               else                  w_nxt = S_DONE;
            end
         end
         S_P3:    begin w_slot = 1'b1; w_follow = r_ddraw ? S_D3 : S_DONE; end
         S_D3:    begin w_slot = 1'b1; w_follow = S_DONE; end
         S_GAP:   if (r_gap_cnt == '0) w_nxt = r_ret;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
      if (w_slot) w_nxt = (DEAL_GAP > 0) ? S_GAP : w_follow;
      w_enter_slot = (w_nxt == S_P1) || (w_nxt == S_D1) || (w_nxt == S_P2) ||
                     (w_nxt == S_D2) || (w_nxt == S_P3) || (w_nxt == S_D3);
   end

   // State, gap bookkeeping and dealer-draw latch
   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         r_state   <= S_IDLE;
         r_ret     <= S_IDLE;
         r_gap_cnt <= '0;
         r_ddraw   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_slot) begin
            r_gap_cnt <= GAP_LOAD;
            r_ret     <= w_follow;
         end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
         end
         if ((r_state == S_WAIT3) && decide) r_ddraw <= dealer_draw;
      end
   end

   // Registered outputs decoded from the state being entered
   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         new_card    <= '0;
         load_pcard1 <= 1'b0;
         load_pcard2 <= 1'b0;
         load_pcard3 <= 1'b0;
         load_dcard1 <= 1'b0;
         load_dcard2 <= 1'b0;
         load_dcard3 <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         load_pcard1 <= (w_nxt == S_P1);
         load_dcard1 <= (w_nxt == S_D1);
         load_pcard2 <= (w_nxt == S_P2);
         load_dcard2 <= (w_nxt == S_D2);
         load_pcard3 <= (w_nxt == S_P3);
         load_dcard3 <= (w_nxt == S_D3);
         busy        <= (w_nxt != S_IDLE);
         done        <= (w_nxt == S_DONE);
         if (w_enter_slot) new_card <= w_card;
      end
   end

endmodule

// File: tb/tb_card_deal_seq.sv
// tb_card_deal_seq: scoreboard bench for card_deal_seq with DEAL_GAP=0 and DEAL_GAP=2.
module tb_card_deal_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int R0 = 0;
   int R2 = 0;

   typedef struct {
      int         cyc;
      logic [5:0] strb;   // {p1,d1,p2,d2,p3,d3}
      logic [3:0] card;
      logic       done;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];

   logic rst0 = 1'b1, start0 = 1'b0, dec0 = 1'b0, pd0 = 1'b0, dd0 = 1'b0;
   logic rst2 = 1'b1, start2 = 1'b0, dec2 = 1'b0, pd2 = 1'b0, dd2 = 1'b0;
   logic [3:0] card0, card2;
   logic p1_0, p2_0, p3_0, d1_0, d2_0, d3_0, busy0, done0;
   logic p1_2, p2_2, p3_2, d1_2, d2_2, d3_2, busy2, done2;
   logic [5:0] strb0, strb2;
   assign strb0 = {p1_0, d1_0, p2_0, d2_0, p3_0, d3_0};
   assign strb2 = {p1_2, d1_2, p2_2, d2_2, p3_2, d3_2};

   card_deal_seq #(.DEAL_GAP(0), .CARD_MAX(13)) u0 (
      .slow_clock(clk), .resetb(rst0), .start(start0), .decide(dec0),
      .player_draw(pd0), .dealer_draw(dd0), .new_card(card0),
      .load_pcard1(p1_0), .load_pcard2(p2_0), .load_pcard3(p3_0),
      .load_dcard1(d1_0), .load_dcard2(d2_0), .load_dcard3(d3_0),
      .busy(busy0), .done(done0));

   card_deal_seq #(.DEAL_GAP(2), .CARD_MAX(13)) u2 (
      .slow_clock(clk), .resetb(rst2), .start(start2), .decide(dec2),
      .player_draw(pd2), .dealer_draw(dd2), .new_card(card2),
      .load_pcard1(p1_2), .load_pcard2(p2_2), .load_pcard3(p3_2),
      .load_dcard1(d1_2), .load_dcard2(d2_2), .load_dcard3(d3_2),
      .busy(busy2), .done(done2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // counter value held after edge n (counter reads 1 right after the reset edge)
   function automatic int src0(input int n);
      return ((n - R0) % 13) + 1;
   endfunction

   function automatic int src2(input int n);
      return ((n - R2) % 13) + 1;
   endfunction

   task automatic push0(input int c, input logic [5:0] s, input logic [3:0] cd, input logic d);
      exp_t e;
      e.cyc = c; e.strb = s; e.card = cd; e.done = d;
      q0.push_back(e);
   endtask

   task automatic push2(input int c, input logic [5:0] s, input logic [3:0] cd, input logic d);
      exp_t e;
      e.cyc = c; e.strb = s; e.card = cd; e.done = d;
      q2.push_back(e);
   endtask

   // monitor for u0
   logic prev_done0 = 1'b0;
   always @(negedge clk) begin : mon0
      exp_t e;
      if (prev_done0) chk("busy_drop0", {31'd0, busy0}, 32'd0);
      prev_done0 = done0;
      chk("onehot0", {31'd0, ($countones(strb0) <= 1)}, 32'd1);
      if (strb0 != 6'd0 || done0) begin
         if (q0.size() == 0) begin
            chk("unexpected0", {25'd0, strb0, done0}, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("cycle0", e.cyc, cyc);
            chk("strobes0", {26'd0, strb0}, {26'd0, e.strb});
            chk("done0", {31'd0, done0}, {31'd0, e.done});
            chk("busy0", {31'd0, busy0}, 32'd1);
            if (e.strb != 6'd0) chk("card0", {28'd0, card0}, {28'd0, e.card});
         end
      end
   end

   // monitor for u2
   logic prev_done2 = 1'b0;
   always @(negedge clk) begin : mon2
      exp_t e;
      if (prev_done2) chk("busy_drop2", {31'd0, busy2}, 32'd0);
      prev_done2 = done2;
      chk("onehot2", {31'd0, ($countones(strb2) <= 1)}, 32'd1);
      if (strb2 != 6'd0 || done2) begin
         if (q2.size() == 0) begin
            chk("unexpected2", {25'd0, strb2, done2}, 32'd0);
         end else begin
            e = q2.pop_front();
            chk("cycle2", e.cyc, cyc);
            chk("strobes2", {26'd0, strb2}, {26'd0, e.strb});
            chk("done2", {31'd0, done2}, {31'd0, e.done});
            chk("busy2", {31'd0, busy2}, 32'd1);
            if (e.strb != 6'd0) chk("card2", {28'd0, card2}, {28'd0, e.card});
         end
      end
   end

   initial begin : stim
      int n;
      // reset both
      tick();
      R0 = cyc; R2 = cyc;
      rst0 = 1'b0; rst2 = 1'b0;
      chk("reset_outs0", {23'd0, strb0, busy0, done0, card0}, 32'd0);
      chk("reset_outs2", {23'd0, strb2, busy2, done2, card2}, 32'd0);

      // idle with decide pulsing: nothing must move
      dec0 = 1'b1; pd0 = 1'b1; dd0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 10) dec0 = 1'b0;
         chk("idle0", {23'd0, strb0, busy0, done0, card0}, 32'd0);
      end

      // hand A: P1 at card 5, both third cards, draw inputs change after decide
      while (src0(cyc) != 5) tick();
      n = cyc;
      start0 = 1'b1;
      push0(n + 1, 6'b100000, 4'd5, 1'b0);
      push0(n + 2, 6'b010000, 4'd6, 1'b0);
      push0(n + 3, 6'b001000, 4'd7, 1'b0);
      push0(n + 4, 6'b000100, 4'd8, 1'b0);
      tick(); start0 = 1'b0;
      tick(); start0 = 1'b1;           // ignored while busy
      tick(); start0 = 1'b0;
      tick(); tick(); tick();          // now at n+6, in WAIT3
      chk("wait3_busy0", {31'd0, busy0}, 32'd1);
      chk("wait3_strb0", {26'd0, strb0}, 32'd0);
      dec0 = 1'b1; pd0 = 1'b1; dd0 = 1'b1;
      push0(n + 7, 6'b000010, 4'd11, 1'b0);
      push0(n + 8, 6'b000001, 4'd12, 1'b0);
      push0(n + 9, 6'b000000, 4'd0,  1'b1);
      tick();
      dec0 = 1'b0; pd0 = 1'b0; dd0 = 1'b0;
      while (cyc < n + 12) tick();

      // hand B: start with a dropped decide in IDLE, then dealer-only draw
      while (src0(cyc) != 2) tick();
      n = cyc;
      start0 = 1'b1; dec0 = 1'b1; pd0 = 1'b1; dd0 = 1'b1;
      push0(n + 1, 6'b100000, 4'd2, 1'b0);
      push0(n + 2, 6'b010000, 4'd3, 1'b0);
      push0(n + 3, 6'b001000, 4'd4, 1'b0);
      push0(n + 4, 6'b000100, 4'd5, 1'b0);
      tick();
      start0 = 1'b0; dec0 = 1'b0; pd0 = 1'b0; dd0 = 1'b1;
      while (cyc < n + 6) tick();
      dec0 = 1'b1;
      push0(n + 7, 6'b000001, 4'd8, 1'b0);
      push0(n + 8, 6'b000000, 4'd0, 1'b1);
      tick(); dec0 = 1'b0; dd0 = 1'b0;
      while (cyc < n + 11) tick();

      // hand C: no third cards
      while (src0(cyc) != 9) tick();
      n = cyc;
      start0 = 1'b1;
      push0(n + 1, 6'b100000, 4'd9,  1'b0);
      push0(n + 2, 6'b010000, 4'd10, 1'b0);
      push0(n + 3, 6'b001000, 4'd11, 1'b0);
      push0(n + 4, 6'b000100, 4'd12, 1'b0);
      tick(); start0 = 1'b0;
      while (cyc < n + 6) tick();
      dec0 = 1'b1; pd0 = 1'b0; dd0 = 1'b0;
      push0(n + 7, 6'b000000, 4'd0, 1'b1);
      tick(); dec0 = 1'b0;
      while (cyc < n + 10) tick();
      chk("idle_after_c0", {30'd0, busy0, done0}, 32'd0);

      // reset while in D1
      while (src0(cyc) != 1) tick();
      n = cyc;
      start0 = 1'b1;
      push0(n + 1, 6'b100000, 4'd1, 1'b0);
      push0(n + 2, 6'b010000, 4'd2, 1'b0);
      tick(); start0 = 1'b0;
      tick();                          // D1 visible now
      rst0 = 1'b1;
      tick();
      R0 = cyc; rst0 = 1'b0;
      chk("midreset0", {23'd0, strb0, busy0, done0, card0}, 32'd0);
      dec0 = 1'b1; pd0 = 1'b1; dd0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 2) dec0 = 1'b0;
         chk("post_reset_idle0", {23'd0, strb0, busy0, done0, card0}, 32'd0);
      end

      // gap build: P1 at card 12, two idle cycles after every slot
      while (src2(cyc) != 12) tick();
      n = cyc;
      start2 = 1'b1;
      push2(n + 1,  6'b100000, 4'd12, 1'b0);
      push2(n + 4,  6'b010000, 4'd2,  1'b0);
      push2(n + 7,  6'b001000, 4'd5,  1'b0);
      push2(n + 10, 6'b000100, 4'd8,  1'b0);
      tick(); start2 = 1'b0;
      while (cyc < n + 13) tick();
      chk("wait3_busy2", {31'd0, busy2}, 32'd1);
      tick();
      dec2 = 1'b1; pd2 = 1'b1; dd2 = 1'b0;
      push2(n + 15, 6'b000010, 4'd13, 1'b0);
      push2(n + 18, 6'b000000, 4'd0,  1'b1);
      tick(); dec2 = 1'b0; pd2 = 1'b0;
      while (cyc < n + 22) tick();

      chk("q0_drained", q0.size(), 32'd0);
      chk("q2_drained", q2.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
